multicycle_ctrl: RTL
====================

# multicycle_ctrl

Moore state machine that sequences the multicycle RV32I datapath: shared instruction/data memory port, single ALU, instruction register and register file. It takes the opcode from the instruction register plus the ALU zero flag and a memory-ready handshake, and produces per-cycle mux selects and write strobes. Instructions take 3-5 cycles plus memory wait states. It sits beside the ALU-function decoder, which consumes `alu_op`.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `op`  in  7  opcode, instruction register bits [6:0]
- `zero`  in  1  ALU result == 0
- `mem_ready`  in  1  memory completes the current access this cycle
- `pc_write`  out  1  PC register enable
- `adr_src`  out  1  memory address: 0 = PC, 1 = ALU result register
- `mem_write`  out  1  memory write strobe
- `ir_write`  out  1  instruction register and old-PC register enable
- `reg_write`  out  1  register file write enable
- `result_src`  out  2  00 = ALU out register, 01 = read data, 10 = ALU result
- `alu_src_a`  out  2  00 = PC, 01 = old PC, 10 = rs1 data
- `alu_src_b`  out  2  00 = rs2 data, 01 = immediate, 10 = constant 4
- `alu_op`  out  2  00 = add, 01 = subtract, 10 = decode by funct3/funct7
- `imm_src`  out  2  00 = I, 01 = S, 10 = B, 11 = J
- `instr_done`  out  1  one-cycle pulse in the last cycle of every instruction
- `illegal_op`  out  1  one-cycle pulse in DECODE when `op` is unsupported

## Operation
- Supported opcodes:
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-ALU 0010011
  - beq 1100011
  - jal 1101111 (only with macro)
- States:
  - FETCH
  - DECODE
  - MEMADR
  - MEMREAD
  - MEMWB
  - MEMWRITE
  - EXECR
  - EXECI
  - ALUWB
  - BEQ
  - JAL
- Transitions:
  - FETCH→DECODE when `mem_ready`, else stay.
  - DECODE→MEMADR (lw/sw), EXECR, EXECI, BEQ, or JAL; any other op→FETCH with `illegal_op`.
  - MEMADR→MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD→MEMWB when `mem_ready`, else stay.
  - MEMWB→FETCH.
  - MEMWRITE→FETCH when `mem_ready`, else stay.
  - EXECR, EXECI and JAL→ALUWB.
  - ALUWB→FETCH.
  - BEQ→FETCH.
- Per-state outputs; unlisted outputs are 0:
  - FETCH: a=00, b=10, alu_op=00, result_src=10, adr_src=0; `ir_write`=`pc_write`=`mem_ready`.
  - DECODE: a=01, b=01, alu_op=00 (branch target precomputed).
  - MEMADR: a=10, b=01, alu_op=00.
  - MEMREAD: adr_src=1.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1; mem_write=1 held until `mem_ready`.
  - EXECR: a=10, b=00, alu_op=10.
  - EXECI: a=10, b=01, alu_op=10.
  - ALUWB: result_src=00, reg_write=1.
  - BEQ: a=10, b=00, alu_op=01, result_src=00; `pc_write`=`zero`.
  - JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1.
- `imm_src` is decoded combinationally from `op` in every state:
  - lw, I-ALU → 00
  - sw → 01
  - beq → 10
  - jal → 11
  - other → 00
- `instr_done` is high in:
  - MEMWB
  - ALUWB
  - BEQ
  - MEMWRITE when `mem_ready`
- `op` is sampled only in DECODE and MEMADR; it may change in any other state.

## Timing
- All outputs are combinational from state, except gating by `mem_ready`/`zero` as listed; there is no registered output delay.
- Minimum cycles with `mem_ready` tied high:
  - lw: 5
  - sw, R-type, I-ALU, jal: 4
  - beq: 3
- Each low cycle of `mem_ready` in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Reset:
  - `rst` high at a clock edge forces FETCH from any state, mid-instruction included.
  - While `rst` is high: `pc_write`, `ir_write`, `mem_write`, `reg_write`, `instr_done` and `illegal_op` are forced 0; selects show FETCH values.
  - The first FETCH access starts in the cycle after `rst` deasserts.
- `mem_ready` is ignored in all states other than FETCH, MEMREAD and MEMWRITE.
- `zero` is used only in BEQ.

## Configuration
- `MULTICYCLE_JAL_EN` defined:
  - jal decodes to JAL then ALUWB.
  - `imm_src`=11 for 1101111.
- Undefined:
  - the JAL state is absent.
  - 1101111 is illegal: `illegal_op` pulses, return to FETCH, no register or PC write beyond the fetch increment.
  - `imm_src` for 1101111 is 00.

## Test plan
- Reset during MEMREAD (lw, `mem_ready`=0) → next cycle FETCH, `reg_write`=0, `ir_write`=0 while `rst`=1.
- lw with `mem_ready`=1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; `reg_write`=1 and `instr_done`=1 only in cycle 5; `result_src`=01.
- sw with `mem_ready` low 2 cycles in MEMWRITE → `mem_write`=1 for 3 cycles, `instr_done` in the third, total 6 cycles.
- beq with `zero`=1 and with `zero`=0 → 3 cycles each; `pc_write`=1 in BEQ only when `zero`=1; `alu_op`=01.
- `op`=0000000 → `illegal_op` pulse in DECODE, back in FETCH next cycle, no `reg_write`/`mem_write`.
- jal with macro → 4 cycles, JAL cycle shows `pc_write`=1, a=01, b=10; without macro → `illegal_op` pulse as above.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore sequencer for a multicycle RV32I datapath with a
// shared instruction/data memory port, one ALU, instruction register and
// register file. Instructions take 3-5 cycles plus memory wait states.
//
// Optional feature macro: MULTICYCLE_JAL_EN (adds the jal opcode and JAL state).
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   op            opcode from instruction register bits [6:0]
//   zero          ALU result == 0 (used only in BEQ)
//   mem_ready     memory completes the current access this cycle
//   pc_write      PC register enable
//   adr_src       memory address select (0 = PC, 1 = ALU result register)
//   mem_write     memory write strobe
//   ir_write      instruction register / old-PC register enable
//   reg_write     register file write enable
//   result_src    00 = ALU out reg, 01 = read data, 10 = ALU result
//   alu_src_a     00 = PC, 01 = old PC, 10 = rs1 data
//   alu_src_b     00 = rs2 data, 01 = immediate, 10 = constant 4
//   alu_op        00 = add, 01 = subtract, 10 = decode by funct3/funct7
//   imm_src       00 = I, 01 = S, 10 = B, 11 = J
//   instr_done    pulse in the last cycle of every instruction
//   illegal_op    pulse in DECODE for an unsupported opcode
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam int unsigned OP_W  = 7;
  localparam int unsigned SEL_W = 2;

  localparam logic [OP_W-1:0] OP_LW   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW   = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYP = 7'b0110011;
  localparam logic [OP_W-1:0] OP_IALU = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ  = 7'b1100011;
`ifdef MULTICYCLE_JAL_EN
  localparam logic [OP_W-1:0] OP_JAL  = 7'b1101111;
`endif

  localparam logic [SEL_W-1:0] A_PC    = 2'b00;
  localparam logic [SEL_W-1:0] A_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] A_RS1   = 2'b10;
  localparam logic [SEL_W-1:0] B_RS2   = 2'b00;
  localparam logic [SEL_W-1:0] B_IMM   = 2'b01;
  localparam logic [SEL_W-1:0] B_FOUR  = 2'b10;
  localparam logic [SEL_W-1:0] ALU_ADD = 2'b00;
  localparam logic [SEL_W-1:0] ALU_SUB = 2'b01;
  localparam logic [SEL_W-1:0] ALU_FN  = 2'b10;
  localparam logic [SEL_W-1:0] RES_OUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_RD  = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALU = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ
`ifdef MULTICYCLE_JAL_EN
    , S_JAL
`endif
  } state_t;

  state_t state;
  state_t state_next;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_LW, OP_IALU: imm_src = 2'b00;
      OP_SW:          imm_src = 2'b01;
      OP_BEQ:         imm_src = 2'b10;
`ifdef MULTICYCLE_JAL_EN
      OP_JAL:         imm_src = 2'b11;
`endif
      default:        imm_src = 2'b00;
    endcase
  end

  // Next-state and per-state outputs
  always_comb begin
    state_next = state;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_OUT;
    alu_src_a  = A_PC;
    alu_src_b  = B_RS2;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (state)
      S_FETCH: begin
        alu_src_a  = A_PC;
        alu_src_b  = B_FOUR;
        alu_op     = ALU_ADD;
        result_src = RES_ALU;
        adr_src    = 1'b0;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target from the old PC while decoding
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        alu_op    = ALU_ADD;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYP:      state_next = S_EXECR;
          OP_IALU:      state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
`ifdef MULTICYCLE_JAL_EN
          OP_JAL:       state_next = S_JAL;
`endif
          default: begin
            illegal_op = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = A_RS1;
        alu_src_b  = B_IMM;
        alu_op     = ALU_ADD;
        state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_RD;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        // Strobe is held until memory accepts the write
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = A_RS1;
        alu_src_b  = B_RS2;
        alu_op     = ALU_FN;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = A_RS1;
        alu_src_b  = B_IMM;
        alu_op     = ALU_FN;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_OUT;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        // PC takes the target computed in DECODE only when operands match
        alu_src_a  = A_RS1;
        alu_src_b  = B_RS2;
        alu_op     = ALU_SUB;
        result_src = RES_OUT;
        pc_write   = zero;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
`ifdef MULTICYCLE_JAL_EN
      S_JAL: begin
        // PC <= target, ALU forms old PC + 4 for the link register
        alu_src_a  = A_OLDPC;
        alu_src_b  = B_FOUR;
        alu_op     = ALU_ADD;
        result_src = RES_OUT;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
`endif
      default: state_next = S_FETCH;
    endcase

    // Reset masks every strobe and shows the FETCH selects
    if (rst) begin
      pc_write   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      adr_src    = 1'b0;
      result_src = RES_ALU;
      alu_src_a  = A_PC;
      alu_src_b  = B_FOUR;
      alu_op     = ALU_ADD;
    end
  end

endmodule
